// File: rtl/pci_pkg.sv
// pci_pkg: definitions shared by the PCI-style initiator and target controllers.
//   - bus command codes presented on c_be during the address phase
//   - target FSM state encoding (also exported on the target's debug port)
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    localparam logic [2:0] STATE_IDLE = 3'd0;
    localparam logic [2:0] STATE_BUSY = 3'd1;
    localparam logic [2:0] STATE_DSEL = 3'd2;
    localparam logic [2:0] STATE_WAIT = 3'd3;
    localparam logic [2:0] STATE_DATA = 3'd4;
    localparam logic [2:0] STATE_DONE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = STATE_IDLE,
        ST_BUSY = STATE_BUSY,
        ST_DSEL = STATE_DSEL,
        ST_WAIT = STATE_WAIT,
        ST_DATA = STATE_DATA,
        ST_DONE = STATE_DONE
    } tgt_state_e;

    function automatic logic is_mem_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_WRITE);
    endfunction

endpackage

// File: rtl/pci_target_mem.sv
// pci_target_mem: dword storage behind the target window.
//   clk   - write clock
//   addr  - dword index, shared by the write and read ports
//   be_we - per-byte write enables (bit i writes wdata[8i+7:8i])
//   wdata - write data
//   rdata - asynchronous read of mem[addr]
// Contents are deliberately not reset.
module pci_target_mem #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [3:0]            be_we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be_we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/pci_target_controller.sv
// pci_target_controller: target end of the PCI-style bus.
// Claims memory reads/writes that fall inside a fixed dword window and
// serves single or burst transfers (wrapping inside the window) from a
// local array, optionally delaying the first data phase.
//   clk    - bus clock, rising-edge sampled
//   rst    - asynchronous active-high reset
//   ad     - address/data; driven by this target only in read data phases
//   c_be   - command (address phase) / byte enables (data phases)
//   frame  - initiator frame
//   irdy   - initiator ready
//   trdy   - target ready
//   devsel - device select
//   state  - current FSM state (debug)
//
// state | meaning
// IDLE  | bus idle, watching for an address phase
// BUSY  | another device's cycle, wait for bus idle
// DSEL  | claimed; devsel up, read turnaround
// WAIT  | target wait states before the first data phase
// DATA  | trdy up, transfer on every irdy edge
// DONE  | final phase taken, outputs dropped, wait for bus idle
module pci_target_controller
    import pci_pkg::*;
#(
    parameter logic [31:0] BAR_BASE    = 32'h0000_1000,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire [31:0] ad,
    input  logic [3:0] c_be,
    input  logic       frame,
    input  logic       irdy,
    output logic       trdy,
    output logic       devsel,
    output logic [2:0] state
);

    localparam int unsigned TAG_LSB   = DEPTH_LOG2 + 2;
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

    tgt_state_e            state_q;
    logic                  devsel_q;
    logic                  trdy_q;
    logic                  ad_oe_q;
    logic                  is_read_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic [2:0]            wait_cnt_q;

    logic                  is_hit;
    logic                  bus_idle;
    logic                  xfer;
    logic [3:0]            mem_be_we;
    logic [31:0]           mem_rdata;

    assign is_hit   = (ad[31:TAG_LSB] == BAR_BASE[31:TAG_LSB]) && is_mem_cmd(c_be);
    assign bus_idle = !frame && !irdy;
    assign xfer     = (state_q == ST_DATA) && trdy_q && irdy;

    // Byte lanes commit only on a real write transfer edge.
    assign mem_be_we = (xfer && !is_read_q) ? c_be : 4'b0000;

    pci_target_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk  (clk),
        .addr (ptr_q),
        .be_we(mem_be_we),
        .wdata(ad),
        .rdata(mem_rdata)
    );

    assign ad     = ad_oe_q ? mem_rdata : 32'hzzzz_zzzz;
    assign trdy   = trdy_q;
    assign devsel = devsel_q;
    assign state  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            devsel_q   <= 1'b0;
            trdy_q     <= 1'b0;
            ad_oe_q    <= 1'b0;
            is_read_q  <= 1'b0;
            ptr_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame) begin
                        if (is_hit) begin
                            state_q    <= ST_DSEL;
                            devsel_q   <= 1'b1;
                            is_read_q  <= (c_be == CMD_MEM_READ);
                            ptr_q      <= ad[TAG_LSB-1:2];
                            wait_cnt_q <= WAIT_INIT;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end

                ST_BUSY: begin
                    if (bus_idle) begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_DSEL: begin
                    if (bus_idle) begin
                        state_q  <= ST_IDLE;
                        devsel_q <= 1'b0;
                    end else if (wait_cnt_q != 3'd0) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_DATA;
                        trdy_q  <= 1'b1;
                        ad_oe_q <= is_read_q;
                    end
                end

                ST_WAIT: begin
                    if (bus_idle) begin
                        state_q  <= ST_IDLE;
                        devsel_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                        // Terminal count: the last wait cycle hands over to DATA.
                        if (wait_cnt_q == 3'd1) begin
                            state_q <= ST_DATA;
                            trdy_q  <= 1'b1;
                            ad_oe_q <= is_read_q;
                        end
                    end
                end

                ST_DATA: begin
                    if (xfer) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (!frame) begin
                            state_q  <= ST_DONE;
                            trdy_q   <= 1'b0;
                            devsel_q <= 1'b0;
                            ad_oe_q  <= 1'b0;
                        end
                    end else if (bus_idle) begin
                        state_q  <= ST_IDLE;
                        trdy_q   <= 1'b0;
                        devsel_q <= 1'b0;
                        ad_oe_q  <= 1'b0;
                    end
                end

                ST_DONE: begin
                    if (bus_idle) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    trdy_q   <= 1'b0;
                    devsel_q <= 1'b0;
                    ad_oe_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_target_controller.sv
module tb_pci_target_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  c_be = 4'h0;
    logic        frame = 1'b0;
    logic        irdy = 1'b0;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_ad = 32'h0;
    wire  [31:0] ad;

    logic        trdy0, devsel0, trdy_w, devsel_w;
    logic [2:0]  state0, state_w;
    logic        trdy_any, devsel_any;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    assign ad         = tb_oe ? tb_ad : 32'hzzzz_zzzz;
    assign trdy_any   = trdy0 | trdy_w;
    assign devsel_any = devsel0 | devsel_w;

    always #5 clk = ~clk;

    // Window at 0x1000, no target wait states.
    pci_target_controller #(
        .BAR_BASE(32'h0000_1000), .DEPTH_LOG2(4), .WAIT_STATES(0)
    ) dut0 (
        .clk(clk), .rst(rst), .ad(ad), .c_be(c_be), .frame(frame), .irdy(irdy),
        .trdy(trdy0), .devsel(devsel0), .state(state0)
    );

    // Window at 0x3000, three target wait states.
    pci_target_controller #(
        .BAR_BASE(32'h0000_3000), .DEPTH_LOG2(4), .WAIT_STATES(3)
    ) dut_w (
        .clk(clk), .rst(rst), .ad(ad), .c_be(c_be), .frame(frame), .irdy(irdy),
        .trdy(trdy_w), .devsel(devsel_w), .state(state_w)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: whenever a target presents read data, compare against the scoreboard.
    always @(negedge clk) begin
        if (!rst && trdy_any && !tb_oe) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got %h expected no read data at %0t", ad, $time);
            end else if (irdy) begin
                chk("rd_data", ad, exp_q.pop_front());
            end else begin
                chk("rd_hold", ad, exp_q[0]);
            end
        end
    end

    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] cmd, input logic [3:0] be,
                            input int n, input int stall_at, input int exp_lat,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] wd [4];
        int i, cyc, lat, stall;
        logic is_wr, xf;
        wd    = '{w0, w1, w2, w3};
        is_wr = (cmd == 4'b0111);
        i = 0; cyc = 0; lat = -1; stall = 0;
        frame = 1'b1; tb_oe = 1'b1; tb_ad = addr; c_be = cmd;
        @(posedge clk); #1;
        chk("dsel_after_addr", {31'b0, devsel_any}, 32'd1);
        chk("trdy_after_addr", {31'b0, trdy_any}, 32'd0);
        if (is_wr) tb_ad = wd[0];
        else       tb_oe = 1'b0;
        c_be  = be;
        irdy  = 1'b1;
        frame = (n > 1);
        while (i < n && cyc < 40) begin
            @(negedge clk);
            if (trdy_any && lat < 0) lat = cyc;
            xf = irdy && trdy_any;
            @(posedge clk); #1;
            cyc++;
            if (xf) begin
                i++;
                if (i < n) begin
                    if (is_wr) tb_ad = wd[i];
                    frame = (i < n - 1);
                    if (i == stall_at) begin
                        irdy  = 1'b0;
                        stall = 3;
                    end
                end
            end else if (stall > 0) begin
                stall--;
                if (stall == 0) irdy = 1'b1;
            end
        end
        if (i < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_timeout: got %0d phases expected %0d", i, n);
        end
        chk("trdy_lat", lat, exp_lat);
        chk("end_trdy", {31'b0, trdy_any}, 32'd0);
        chk("end_devsel", {31'b0, devsel_any}, 32'd0);
        chk("end_state", (addr >= 32'h3000) ? {29'b0, state_w} : {29'b0, state0}, 32'd5);
        irdy = 1'b0; frame = 1'b0; tb_oe = 1'b0;
        @(posedge clk); #1;
        chk("idle_state", {29'b0, state0}, 32'd0);
    endtask

    task automatic bus_miss(input logic [31:0] addr, input logic [3:0] cmd);
        frame = 1'b1; tb_oe = 1'b1; tb_ad = addr; c_be = cmd;
        @(posedge clk); #1;
        frame = 1'b0; irdy = 1'b1; tb_oe = 1'b0; c_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("miss_devsel", {31'b0, devsel_any}, 32'd0);
            chk("miss_trdy", {31'b0, trdy_any}, 32'd0);
        end
        chk("miss_busy", {29'b0, state0}, 32'd1);
        @(posedge clk); #1;
        irdy = 1'b0;
        @(posedge clk); #1;
        chk("miss_idle", {29'b0, state0}, 32'd0);
    endtask

    initial begin
        int budget;
        #12;
        chk("rst_trdy", {31'b0, trdy0}, 32'd0);
        chk("rst_devsel", {31'b0, devsel0}, 32'd0);
        chk("rst_state", {29'b0, state0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write then read.
        bus_xfer(32'h1004, 4'b0111, 4'hF, 1, -1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        exp_q.push_back(32'hDEAD_BEEF);
        bus_xfer(32'h1004, 4'b0110, 4'hF, 1, -1, 1, 0, 0, 0, 0);

        // Byte-enable merge.
        bus_xfer(32'h1008, 4'b0111, 4'hF, 1, -1, 1, 32'h1122_3344, 0, 0, 0);
        bus_xfer(32'h1008, 4'b0111, 4'b0101, 1, -1, 1, 32'hAABB_CCDD, 0, 0, 0);
        exp_q.push_back(32'h11BB_33DD);
        bus_xfer(32'h1008, 4'b0110, 4'hF, 1, -1, 1, 0, 0, 0, 0);

        // Burst write wrapping 14, 15, 0, 1 then burst read back.
        bus_xfer(32'h1038, 4'b0111, 4'hF, 4, -1, 1,
                 32'hA000_000E, 32'hA000_000F, 32'hA000_0000, 32'hA000_0001);
        exp_q.push_back(32'hA000_000E); exp_q.push_back(32'hA000_000F);
        exp_q.push_back(32'hA000_0000); exp_q.push_back(32'hA000_0001);
        bus_xfer(32'h1038, 4'b0110, 4'hF, 4, -1, 1, 0, 0, 0, 0);
        exp_q.push_back(32'hA000_0000);
        bus_xfer(32'h1000, 4'b0110, 4'hF, 1, -1, 1, 0, 0, 0, 0);

        // Initiator stalls 3 cycles before the third phase of a burst read.
        exp_q.push_back(32'hA000_000E); exp_q.push_back(32'hA000_000F);
        exp_q.push_back(32'hA000_0000); exp_q.push_back(32'hA000_0001);
        bus_xfer(32'h1038, 4'b0110, 4'hF, 4, 2, 1, 0, 0, 0, 0);

        // Misses: outside window, and unsupported command inside it.
        bus_miss(32'h2000, 4'b0110);
        bus_miss(32'h1000, 4'b0010);

        // Target wait states: trdy three cycles later than the zero-wait target.
        bus_xfer(32'h3008, 4'b0111, 4'hF, 1, -1, 4, 32'h5A5A_0F0F, 0, 0, 0);
        exp_q.push_back(32'h5A5A_0F0F);
        bus_xfer(32'h3008, 4'b0110, 4'hF, 1, -1, 4, 0, 0, 0, 0);

        chk("sb_empty", exp_q.size(), 32'd0);

        // Reset in the middle of a burst read.
        exp_q.push_back(32'hA000_000E);
        frame = 1'b1; tb_oe = 1'b1; tb_ad = 32'h1038; c_be = 4'b0110;
        @(posedge clk); #1;
        tb_oe = 1'b0; c_be = 4'hF; irdy = 1'b0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!trdy0 && budget < 10);
        chk("rst_mid_reached_data", {31'b0, trdy0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_trdy", {31'b0, trdy0}, 32'd0);
        chk("rst_mid_devsel", {31'b0, devsel0}, 32'd0);
        chk("rst_mid_state", {29'b0, state0}, 32'd0);
        frame = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        bus_xfer(32'h1010, 4'b0111, 4'hF, 1, -1, 1, 32'hC0FF_EE00, 0, 0, 0);
        exp_q.push_back(32'hC0FF_EE00);
        bus_xfer(32'h1010, 4'b0110, 4'hF, 1, -1, 1, 0, 0, 0, 0);
        chk("sb_empty_end", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pci_target_controller.md
Name: pci_target_controller

Overview:
- Responder (target) end of the bus that the initiator controller drives.
- Decodes each address phase against a fixed memory window and claims the cycle with devsel.
- Serves single and burst memory reads and writes from an internal dword array, with optional initial wait states.
- Control signals are logical active-high (1 = asserted), matching the initiator controller.

Parameters:
- BAR_BASE, 32'h0000_1000, byte base address of the window; aligned to window size
- DEPTH_LOG2, 4, window holds 2**DEPTH_LOG2 dwords
- WAIT_STATES, 0, target wait cycles inserted before the first data phase (0..7)

Ports:
- clk  input  1  bus clock; all sampling on rising edge
- rst  input  1  asynchronous, active-high reset
- ad  inout  32  multiplexed address/data; driven only during read data phases
- c_be  input  4  command in address phase; byte enables (1 = lane enabled) in data phases
- frame  input  1  initiator frame
- irdy  input  1  initiator ready
- trdy  output  1  target ready
- devsel  output  1  device select (fast decode)
- state  output  3  current FSM state, for debug and bench

Behaviour:
- Reset (async, immediate): trdy=0, devsel=0, ad released (high-Z), state=IDLE. Memory contents are not reset.
- Address phase: a rising edge in IDLE with frame=1.
  - Sample ad and c_be.
  - Hit when ad[31:DEPTH_LOG2+2] equals BAR_BASE[31:DEPTH_LOG2+2] and c_be is 4'b0110 (mem read) or 4'b0111 (mem write).
  - ad[1:0] is ignored.
- States, encoded 0..5:
  - IDLE
    - hit: go to DSEL; devsel=1 from the next cycle.
    - miss with frame=1: go to BUSY.
  - BUSY: another device's cycle. Ignore the bus until frame=0 and irdy=0 are sampled, then go to IDLE.
  - DSEL: devsel=1, trdy=0, one cycle.
    - Read: this is the turnaround cycle; ad stays high-Z.
    - Then go to WAIT if the wait counter is nonzero, else DATA.
  - WAIT: counts down WAIT_STATES cycles with devsel=1, trdy=0, then goes to DATA. Only the first data phase is delayed.
  - DATA: devsel=1, trdy=1.
    - Read: ad is driven with mem[ptr].
    - A transfer occurs on every edge where irdy=1 and trdy=1.
    - Read transfer: the ad value is taken by the initiator.
    - Write transfer: mem[ptr] is updated lane by lane where c_be[i]=1.
    - Every transfer: ptr <= ptr+1 modulo 2**DEPTH_LOG2 (burst wraps inside the window).
    - A transfer with frame=0 is the final data phase: go to DONE.
    - irdy=0: initiator wait. Hold trdy=1, hold the ad value, no pointer change.
  - DONE: trdy=0, devsel=0, ad released in the same cycle. Go to IDLE when frame=0 and irdy=0 are sampled; fast back-to-back cycles are not supported.
- Latency with WAIT_STATES=0, address phase at edge N:
  - devsel rises after edge N.
  - trdy rises after edge N+1, for both read and write.
  - Read data is valid from after edge N+1.
  - Each further data phase transfers in one cycle while irdy=1.
- ptr is loaded from ad[DEPTH_LOG2+1:2] at the address phase.
- frame=0 with irdy=0 while in DSEL/WAIT/DATA is an initiator abort: go to IDLE, drop all outputs.
- Reset mid-transfer: outputs drop immediately. A write byte-lane update is committed only on a valid transfer edge.
- Unsupported commands (I/O, config, etc.) are treated as misses.

Decomposition:
- Shared package pci_pkg:
  - command codes CMD_MEM_READ=4'b0110, CMD_MEM_WRITE=4'b0111
  - state encoding localparams
- pci_pkg is also adopted by the initiator controller, so both ends agree.
- One sub-module: pci_target_mem, DEPTH-dword array with per-byte write enables and an asynchronous read port.
- Decode, FSM and tristate control live in the top module.

Test Plan:
- Single write then read, WAIT_STATES=0:
  - Write 0xDEADBEEF to 0x1004 with c_be=4'hF -> devsel after edge N, trdy after N+1, transfer at N+2.
  - Read of 0x1004 -> ad=0xDEADBEEF driven after the turnaround cycle.
- Byte-enable write: 0x11223344 to 0x1008, then 0xAABBCCDD with c_be=4'b0101 -> readback 0x11BB33DD.
- Burst with wrap, DEPTH_LOG2=4:
  - Four-dword write starting at 0x1038 -> lands in dwords 14, 15, 0, 1.
  - Burst read from 0x1038 returns them in order.
  - Final phase ends with trdy/devsel=0 the next cycle.
- Initiator wait states: irdy held 0 for 3 cycles mid-burst read -> trdy stays 1, ad stable, ptr unchanged, no duplicate or skipped data.
- Miss, wrong command and wait states:
  - Address 0x2000 read, or command 4'b0010 at 0x1000 -> devsel and trdy never assert; state goes to BUSY until the bus is idle.
  - With WAIT_STATES=3 -> trdy first asserts 3 cycles later than in the WAIT_STATES=0 case.
- Reset mid-burst: assert rst during DATA of a read -> trdy=0, devsel=0, ad high-Z within the same cycle; a clean transaction after reset succeeds.
